// File: rtl/ctrl_sequencer.sv
// Instruction-cycle sequencer: owns the IDLE/LOAD/FETCH/DECODE/EXEC/WAIT/HALT stage FSM,
// counts program-load addresses, inserts data-memory wait states and decodes all datapath enables.
module ctrl_sequencer #(
  parameter int IR_W       = 12,
  parameter int PADDR_W    = 8,
  parameter int LOAD_WORDS = 256,
  parameter int DMEM_WAIT  = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [IR_W-1:0]    ir,
  input  logic [3:0]         sr,
  output logic [2:0]         stage,
  output logic [PADDR_W-1:0] load_addr,
  output logic               pc_e,
  output logic               acc_e,
  output logic               sr_e,
  output logic               ir_e,
  output logic               dr_e,
  output logic               pmem_e,
  output logic               pmem_le,
  output logic               dmem_e,
  output logic               dmem_we,
  output logic               alu_e,
  output logic               mux1_sel,
  output logic               mux2_sel,
  output logic [3:0]         alu_mode,
  output logic               halted
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_FETCH  = 3'd2;
  localparam logic [2:0] S_DECODE = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_WAIT   = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic               HAS_WAIT  = (DMEM_WAIT != 0);
  localparam logic [3:0]         WAIT_INIT = (DMEM_WAIT > 0) ? 4'(DMEM_WAIT - 1) : 4'd0;
  localparam logic [PADDR_W-1:0] LAST_ADDR = PADDR_W'(LOAD_WORDS - 1);

  logic [2:0]         state_q, state_d;
  logic [PADDR_W-1:0] load_addr_q, load_addr_d;
  logic [3:0]         wait_q, wait_d;

  logic [3:0] op;
  logic       is_m;
  logic       is_load;
  logic       mem_active;
  logic       m_commit;
  logic       unused_ir;

  assign op        = ir[IR_W-1:IR_W-4];
  assign is_m      = (op[3:1] == 3'b001);
  assign is_load   = op[0];
  assign unused_ir = ^ir;
  assign load_addr = load_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      load_addr_q <= '0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      load_addr_q <= load_addr_d;
      wait_q      <= wait_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    load_addr_d = load_addr_q;
    wait_d      = wait_q;
    case (state_q)
      S_IDLE: begin
        load_addr_d = '0;
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (load_addr_q == LAST_ADDR) begin
          state_d     = S_FETCH;
          load_addr_d = '0;
        end else begin
          load_addr_d = load_addr_q + 1'b1;
        end
      end
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (op == 4'b0000 && ir[0]) begin
          state_d = S_HALT;
        end else if (is_m && HAS_WAIT) begin
          state_d = S_WAIT;
          wait_d  = WAIT_INIT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_WAIT: begin
        if (wait_q == 4'd0) state_d = S_FETCH;
        else                wait_d  = wait_q - 1'b1;
      end
      S_HALT: if (start) state_d = S_FETCH;
      default: begin
        state_d     = S_IDLE;
        load_addr_d = '0;
        wait_d      = '0;
      end
    endcase
  end

  // Memory instructions only commit (PC/ACC/SR/write) on their last EXEC/WAIT cycle.
  assign mem_active = (state_q == S_WAIT) || (state_q == S_EXEC && is_m);
  assign m_commit   = (state_q == S_WAIT) ? (wait_q == 4'd0) : !HAS_WAIT;

  always_comb begin
    stage    = 3'd0;
    pc_e     = 1'b0;
    acc_e    = 1'b0;
    sr_e     = 1'b0;
    ir_e     = 1'b0;
    dr_e     = 1'b0;
    pmem_e   = 1'b0;
    pmem_le  = 1'b0;
    dmem_e   = 1'b0;
    dmem_we  = 1'b0;
    alu_e    = 1'b0;
    mux1_sel = 1'b0;
    mux2_sel = 1'b0;
    alu_mode = 4'd0;
    halted   = 1'b0;
    if (state_q != 3'd7) stage = state_q;
    case (state_q)
      S_LOAD: begin
        pmem_le = 1'b1;
        pmem_e  = 1'b1;
      end
      S_FETCH: begin
        ir_e   = 1'b1;
        pmem_e = 1'b1;
      end
      S_DECODE: begin
        dr_e   = is_m;
        dmem_e = is_m;
      end
      S_EXEC: begin
        if (op[3]) begin
          pc_e     = 1'b1;
          acc_e    = 1'b1;
          sr_e     = 1'b1;
          alu_e    = 1'b1;
          alu_mode = {1'b0, op[2:0]};
          mux1_sel = 1'b1;
        end else if (op[3:2] == 2'b01) begin
          pc_e     = 1'b1;
          mux1_sel = sr[op[1:0]];
        end else if (!is_m) begin
          // op is 0001 (jump, mux1=0) or 0000 (NOP/HLT, PC+1)
          pc_e     = 1'b1;
          mux1_sel = (op == 4'b0000);
        end
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
    if (mem_active) begin
      alu_e    = 1'b1;
      alu_mode = ir[IR_W-5:IR_W-8];
      mux1_sel = 1'b1;
      mux2_sel = 1'b1;
      dmem_e   = m_commit ? !is_load : 1'b1;
      if (m_commit) begin
        pc_e    = 1'b1;
        acc_e   = is_load;
        sr_e    = 1'b1;
        dmem_we = !is_load;
      end
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer (LOAD_WORDS=4, DMEM_WAIT=2); expected output
// vectors are queued as stimulus is applied and compared when the DUT is sampled.
module tb_ctrl_sequencer;

  localparam logic [11:0] PC  = 12'h800;
  localparam logic [11:0] ACC = 12'h400;
  localparam logic [11:0] SRE = 12'h200;
  localparam logic [11:0] IRE = 12'h100;
  localparam logic [11:0] DR  = 12'h080;
  localparam logic [11:0] PM  = 12'h040;
  localparam logic [11:0] PLE = 12'h020;
  localparam logic [11:0] DM  = 12'h010;
  localparam logic [11:0] DWE = 12'h008;
  localparam logic [11:0] ALU = 12'h004;
  localparam logic [11:0] M1  = 12'h002;
  localparam logic [11:0] M2  = 12'h001;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] ir;
  logic [3:0]  sr;
  logic [2:0]  stage;
  logic [7:0]  load_addr;
  logic        pc_e, acc_e, sr_e, ir_e, dr_e, pmem_e, pmem_le;
  logic        dmem_e, dmem_we, alu_e, mux1_sel, mux2_sel;
  logic [3:0]  alu_mode;
  logic        halted;
  logic [27:0] obs;

  int tests = 0;
  int fails = 0;
  logic [27:0] exp_q[$];

  ctrl_sequencer #(
    .IR_W(12), .PADDR_W(8), .LOAD_WORDS(4), .DMEM_WAIT(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ir(ir), .sr(sr),
    .stage(stage), .load_addr(load_addr),
    .pc_e(pc_e), .acc_e(acc_e), .sr_e(sr_e), .ir_e(ir_e), .dr_e(dr_e),
    .pmem_e(pmem_e), .pmem_le(pmem_le), .dmem_e(dmem_e), .dmem_we(dmem_we),
    .alu_e(alu_e), .mux1_sel(mux1_sel), .mux2_sel(mux2_sel),
    .alu_mode(alu_mode), .halted(halted)
  );

  assign obs = {stage, load_addr, pc_e, acc_e, sr_e, ir_e, dr_e, pmem_e, pmem_le,
                dmem_e, dmem_we, alu_e, mux1_sel, mux2_sel, alu_mode, halted};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [27:0] mk(input logic [2:0] st, input logic [7:0] a,
                                     input logic [11:0] en, input logic [3:0] m,
                                     input logic h);
    return {st, a, en, m, h};
  endfunction

  task automatic chk(input string tag);
    logic [27:0] e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        fails++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // expectation for the state reached after the next rising edge
  task automatic step(input string tag, input logic [27:0] e);
    exp_q.push_back(e);
    tick();
    chk(tag);
  endtask

  // expectation for the current state (combinational path)
  task automatic now(input string tag, input logic [27:0] e);
    exp_q.push_back(e);
    #1;
    chk(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    ir    = 12'h000;
    sr    = 4'b0000;
    @(negedge clk);
    now("reset", mk(3'd0, 8'd0, 12'h000, 4'h0, 1'b0));

    // Program load, start held high to show it is ignored in LOAD/FETCH
    rst_n = 1'b1;
    start = 1'b1;
    step("load0", mk(3'd1, 8'd0, PM | PLE, 4'h0, 1'b0));
    step("load1", mk(3'd1, 8'd1, PM | PLE, 4'h0, 1'b0));
    step("load2", mk(3'd1, 8'd2, PM | PLE, 4'h0, 1'b0));
    step("load3", mk(3'd1, 8'd3, PM | PLE, 4'h0, 1'b0));
    step("fetch_after_load", mk(3'd2, 8'd0, IRE | PM, 4'h0, 1'b0));
    start = 1'b0;

    ir = 12'hA05;
    step("alu_decode", mk(3'd3, 8'd0, 12'h000, 4'h0, 1'b0));
    step("alu_exec", mk(3'd4, 8'd0, PC | ACC | SRE | ALU | M1, 4'h2, 1'b0));
    step("alu_fetch", mk(3'd2, 8'd0, IRE | PM, 4'h0, 1'b0));

    ir = 12'h600;
    sr = 4'b0100;
    step("cj_decode", mk(3'd3, 8'd0, 12'h000, 4'h0, 1'b0));
    step("cj_exec_taken", mk(3'd4, 8'd0, PC | M1, 4'h0, 1'b0));
    sr = 4'b0000;
    now("cj_exec_not_taken", mk(3'd4, 8'd0, PC, 4'h0, 1'b0));
    step("cj_fetch", mk(3'd2, 8'd0, IRE | PM, 4'h0, 1'b0));

    ir = 12'h230;
    step("st_decode", mk(3'd3, 8'd0, DR | DM, 4'h0, 1'b0));
    step("st_exec_pend", mk(3'd4, 8'd0, DM | ALU | M1 | M2, 4'h3, 1'b0));
    step("st_wait1_pend", mk(3'd5, 8'd0, DM | ALU | M1 | M2, 4'h3, 1'b0));
    step("st_wait2_commit", mk(3'd5, 8'd0, PC | SRE | DM | DWE | ALU | M1 | M2, 4'h3, 1'b0));
    step("st_fetch", mk(3'd2, 8'd0, IRE | PM, 4'h0, 1'b0));

    ir = 12'h351;
    step("ld_decode", mk(3'd3, 8'd0, DR | DM, 4'h0, 1'b0));
    step("ld_exec_pend", mk(3'd4, 8'd0, DM | ALU | M1 | M2, 4'h5, 1'b0));
    step("ld_wait1_pend", mk(3'd5, 8'd0, DM | ALU | M1 | M2, 4'h5, 1'b0));
    step("ld_wait2_commit", mk(3'd5, 8'd0, PC | ACC | SRE | ALU | M1 | M2, 4'h5, 1'b0));
    step("ld_fetch", mk(3'd2, 8'd0, IRE | PM, 4'h0, 1'b0));

    ir = 12'h1FF;
    step("jmp_decode", mk(3'd3, 8'd0, 12'h000, 4'h0, 1'b0));
    step("jmp_exec", mk(3'd4, 8'd0, PC, 4'h0, 1'b0));
    step("jmp_fetch", mk(3'd2, 8'd0, IRE | PM, 4'h0, 1'b0));

    ir = 12'h001;
    step("hlt_decode", mk(3'd3, 8'd0, 12'h000, 4'h0, 1'b0));
    step("hlt_exec", mk(3'd4, 8'd0, PC | M1, 4'h0, 1'b0));
    step("halt1", mk(3'd6, 8'd0, 12'h000, 4'h0, 1'b1));
    step("halt2", mk(3'd6, 8'd0, 12'h000, 4'h0, 1'b1));
    step("halt3", mk(3'd6, 8'd0, 12'h000, 4'h0, 1'b1));
    start = 1'b1;
    step("restart_fetch", mk(3'd2, 8'd0, IRE | PM, 4'h0, 1'b0));
    start = 1'b0;

    ir = 12'h000;
    step("nop_decode", mk(3'd3, 8'd0, 12'h000, 4'h0, 1'b0));
    step("nop_exec", mk(3'd4, 8'd0, PC | M1, 4'h0, 1'b0));
    step("nop_fetch", mk(3'd2, 8'd0, IRE | PM, 4'h0, 1'b0));

    ir = 12'h230;
    step("rst_st_decode", mk(3'd3, 8'd0, DR | DM, 4'h0, 1'b0));
    step("rst_st_exec", mk(3'd4, 8'd0, DM | ALU | M1 | M2, 4'h3, 1'b0));
    step("rst_st_wait1", mk(3'd5, 8'd0, DM | ALU | M1 | M2, 4'h3, 1'b0));
    #2;
    rst_n = 1'b0;
    now("rst_async", mk(3'd0, 8'd0, 12'h000, 4'h0, 1'b0));
    @(negedge clk);
    now("rst_held", mk(3'd0, 8'd0, 12'h000, 4'h0, 1'b0));
    rst_n = 1'b1;
    start = 1'b1;
    step("reload0", mk(3'd1, 8'd0, PM | PLE, 4'h0, 1'b0));
    start = 1'b0;
    step("reload1", mk(3'd1, 8'd1, PM | PLE, 4'h0, 1'b0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Parametrised successor to the combinational control decoder of the 8-bit microcontroller.
- Owns the instruction-cycle stage FSM: IDLE, LOAD, FETCH, DECODE, EXEC, WAIT, HALT.
- Counts program-load addresses itself and inserts configurable data-memory wait states.
- Adds a halt instruction with restart. Drives all datapath enables; sits between the program/data memories and the ALU/register datapath.

Parameters:
- IR_W, 12, instruction width (≥12); opcode field OP = IR[IR_W-1:IR_W-4].
- PADDR_W, 8, program-load address width.
- LOAD_WORDS, 256, words written during LOAD (1..2^PADDR_W).
- DMEM_WAIT, 0, extra EXEC cycles for memory-type instructions (0..15).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse: IDLE→LOAD, HALT→FETCH; ignored in other states.
- ir  in  IR_W  instruction register contents.
- sr  in  4  status flags {O,S,C,Z} indexed 3..0.
- stage  out  3  state code: IDLE=0, LOAD=1, FETCH=2, DECODE=3, EXEC=4, WAIT=5, HALT=6.
- load_addr  out  PADDR_W  program-memory write address during LOAD.
- pc_e, acc_e, sr_e, ir_e, dr_e, pmem_e, pmem_le, dmem_e, dmem_we, alu_e, mux1_sel, mux2_sel  out  1 each  datapath enables/selects.
- alu_mode  out  4  ALU operation.
- halted  out  1  high in HALT.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, load_addr=0, wait counter=0. All outputs 0; stage=0.
- Outputs are decoded combinationally from state, ir, sr and the wait counter. Default for every output is 0.
- IDLE: all outputs 0. start=1 → LOAD, load_addr cleared to 0.
- LOAD:
  - pmem_le=pmem_e=1; load_addr increments each cycle.
  - In the cycle with load_addr==LOAD_WORDS-1, next state is FETCH and load_addr returns to 0.
  - Exactly LOAD_WORDS cycles are spent in LOAD.
- FETCH: ir_e=pmem_e=1; next state DECODE.
- DECODE: dr_e=dmem_e=1 iff OP[3:1]==3'b001; next state EXEC.
- EXEC full decode:
  - OP[3]=1 (ALU I-type): pc_e, acc_e, sr_e, alu_e=1; alu_mode={1'b0,OP[2:0]}; mux1_sel=1, mux2_sel=0.
  - OP[3:2]=01 (conditional jump): pc_e=1; mux1_sel=sr[OP[1:0]].
  - OP[3:1]=001 (M-type), with L=OP[0]:
    - pc_e=1, acc_e=L, sr_e=1, dmem_e=!L, dmem_we=!L, alu_e=1.
    - alu_mode=IR[IR_W-5:IR_W-8]; mux1_sel=mux2_sel=1.
  - OP=0001: unconditional jump; pc_e=1, mux1_sel=0.
  - OP=0000, IR[0]=0: NOP; pc_e=1, mux1_sel=1.
  - OP=0000, IR[0]=1: HLT; pc_e=1, mux1_sel=1 (PC advances past HLT); next state HALT.
  - Every other case: next state FETCH.
- M-type wait states (DMEM_WAIT>0):
  - EXEC and the first DMEM_WAIT-1 WAIT cycles are "pending" cycles: alu_e, alu_mode, mux1_sel, mux2_sel as in the full decode; dmem_e=1 for both load and store; pc_e=acc_e=sr_e=dmem_we=0.
  - EXEC → WAIT, wait counter loaded with DMEM_WAIT-1.
  - WAIT decrements the counter. On the WAIT cycle where the counter is 0, the full M-type decode is asserted (commit), then → FETCH.
  - Total M-type EXEC+WAIT = DMEM_WAIT+1 cycles; dmem_we is high for exactly one cycle (the commit cycle).
  - DMEM_WAIT=0: M-type commits in EXEC; WAIT is never entered.
- HALT: all enables 0, halted=1. start=1 → FETCH.
- start in LOAD/FETCH/DECODE/EXEC/WAIT: ignored, no effect.
- Reset mid-operation (e.g. in LOAD or WAIT): immediate return to IDLE. No partial write is committed after reset deasserts; the load address restarts at 0.
- ir/sr are sampled only combinationally in DECODE/EXEC/WAIT; ir must be stable from FETCH+1 through commit.
- Illegal stage codes 7 → IDLE on next edge, outputs 0.

Test Plan:
- Load (LOAD_WORDS=4): reset, start pulse → stage=1 for exactly 4 cycles, load_addr 0,1,2,3, pmem_le=1 each; then stage=2 with ir_e=pmem_e=1.
- ALU I-type: ir=12'hA05 in EXEC → pc_e=acc_e=sr_e=alu_e=1, alu_mode=4'h2, mux1_sel=1, mux2_sel=0; next stage FETCH.
- Conditional jump: ir=12'h600, sr=4'b0100 → mux1_sel=1 (flag S); sr=4'b0000 → mux1_sel=0; pc_e=1 both.
- Store with DMEM_WAIT=2: ir=12'h230:
  - DECODE: dr_e=dmem_e=1.
  - EXEC, WAIT#1: dmem_e=1, alu_mode=4'h3, dmem_we=0, pc_e=0.
  - WAIT#2: dmem_we=pc_e=sr_e=1, acc_e=0.
  - Then FETCH.
- Halt/restart: ir=12'h001 in EXEC → pc_e=1, mux1_sel=1; next halted=1, all enables 0; start held 3 cycles later → FETCH, halted=0.
- Async reset: assert rst_n=0 mid-WAIT (between edges) → outputs 0 and stage=0 immediately; after release start → load_addr restarts at 0.
